// File: rtl/peripheral_mpi_ahb4_pkg.sv
// Shared AHB encodings and bridge state type for the MPI AHB4-Lite bridge.
package peripheral_mpi_ahb4_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR1,
    ERR2
  } state_t;

  // Channel index width; a single channel still gets one index bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/peripheral_mpi_bus_demux.sv
// Fans the latched request out to one generic-bus channel and muxes that
// channel's ack/err/read data back. Address and write data are broadcast;
// only the selected channel sees en/we.
module peripheral_mpi_bus_demux #(
  parameter int PLEN     = 32,
  parameter int XLEN     = 32,
  parameter int CHANNELS = 1,
  parameter int CH_W     = 1
) (
  input  logic                     i_en,
  input  logic [CH_W-1:0]          i_ch,
  input  logic                     i_we,
  input  logic [PLEN-1:0]          i_addr,
  input  logic [XLEN-1:0]          i_wdata,
  output logic                     o_ack,
  output logic                     o_err,
  output logic [XLEN-1:0]          o_rdata,
  output logic [CHANNELS*PLEN-1:0] bus_addr,
  output logic [CHANNELS-1:0]      bus_we,
  output logic [CHANNELS-1:0]      bus_en,
  output logic [CHANNELS*XLEN-1:0] bus_data_in,
  input  logic [CHANNELS*XLEN-1:0] bus_data_out,
  input  logic [CHANNELS-1:0]      bus_ack,
  input  logic [CHANNELS-1:0]      bus_err
);

  // One-hot select of the addressed channel and return-path mux.
  always_comb begin
    bus_en      = '0;
    bus_we      = '0;
    bus_addr    = '0;
    bus_data_in = '0;
    o_ack       = 1'b0;
    o_err       = 1'b0;
    o_rdata     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus_addr[i*PLEN +: PLEN]    = i_addr;
      bus_data_in[i*XLEN +: XLEN] = i_wdata;
      if (i_en && (i_ch == CH_W'(i))) begin
        bus_en[i] = 1'b1;
        bus_we[i] = i_we;
        o_ack     = bus_ack[i];
        o_err     = bus_err[i];
        o_rdata   = bus_data_out[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/peripheral_mpi_ahb4_bridge.sv
// AHB4-Lite slave bridge onto CHANNELS generic MPI buffer buses.
// Holds the address-phase latch, wait/timeout counter and response FSM.
module peripheral_mpi_ahb4_bridge
  import peripheral_mpi_ahb4_pkg::*;
#(
  parameter int PLEN     = 32,
  parameter int XLEN     = 32,
  parameter int CHANNELS = 1,
  parameter int CH_LSB   = 12,
  parameter int TIMEOUT  = 256,
  parameter int REG_RESP = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ahb4_hsel_i,
  input  logic [PLEN-1:0]          ahb4_haddr_i,
  input  logic [XLEN-1:0]          ahb4_hwdata_i,
  input  logic                     ahb4_hwrite_i,
  input  logic [2:0]               ahb4_hsize_i,
  input  logic [2:0]               ahb4_hburst_i,
  input  logic [3:0]               ahb4_hprot_i,
  input  logic [1:0]               ahb4_htrans_i,
  input  logic                     ahb4_hmastlock_i,
  input  logic                     ahb4_hready_i,
  output logic [XLEN-1:0]          ahb4_hrdata_o,
  output logic                     ahb4_hready_o,
  output logic                     ahb4_hresp_o,
  output logic [CHANNELS*PLEN-1:0] bus_addr,
  output logic [CHANNELS-1:0]      bus_we,
  output logic [CHANNELS-1:0]      bus_en,
  output logic [CHANNELS*XLEN-1:0] bus_data_in,
  input  logic [CHANNELS*XLEN-1:0] bus_data_out,
  input  logic [CHANNELS-1:0]      bus_ack,
  input  logic [CHANNELS-1:0]      bus_err,
  output logic                     timeout_o
);

  localparam int               CH_W      = ch_width(CHANNELS);
  localparam logic [CH_W:0]    CH_LIMIT  = (CH_W+1)'(CHANNELS);
  localparam logic [2:0]       FULL_SIZE = 3'($clog2(XLEN/8));
  localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT-1 : 0);

  state_t              r_state;
  state_t              w_next;
  logic [CH_LSB-1:0]   r_addr;
  logic                r_write;
  logic [CH_W-1:0]     r_ch;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_tmo;
  logic [XLEN-1:0]     r_rdata;

  logic [CH_W-1:0]     w_ch;
  logic                w_dec_err;
  logic                w_can_accept;
  logic                w_accept;
  logic                w_ack;
  logic                w_err;
  logic                w_tmo;
  logic                w_bus_en;
  logic [XLEN-1:0]     w_rdata;
  logic [PLEN-1:0]     w_bus_addr;
  logic                w_unused;

  // Address-phase decode: channel index and illegal-transfer detection.
  assign w_ch      = ahb4_haddr_i[CH_LSB +: CH_W];
  assign w_dec_err = ({1'b0, w_ch} >= CH_LIMIT) ||
                     (ahb4_hwrite_i && (ahb4_hsize_i != FULL_SIZE));

  // A new address phase may only be taken while this slave is completing.
  always_comb begin
    w_can_accept = 1'b0;
    case (r_state)
      IDLE, RESP, ERR2: w_can_accept = 1'b1;
      ACCESS:           w_can_accept = (REG_RESP == 0) && w_ack && !w_err;
      default:          w_can_accept = 1'b0;
    endcase
  end

  assign w_accept = w_can_accept && ahb4_hsel_i && ahb4_htrans_i[1] && ahb4_hready_i;
  assign w_tmo    = (TIMEOUT > 0) && (r_state == ACCESS) && !w_ack && !w_err &&
                    (r_cnt == CNT_LAST);

  assign w_bus_addr = {{(PLEN-CH_LSB){1'b0}}, r_addr};
  assign timeout_o  = r_tmo;
  assign w_unused   = ^{ahb4_haddr_i, ahb4_htrans_i[0], ahb4_hburst_i,
                        ahb4_hprot_i, ahb4_hmastlock_i};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_dec_err ? ERR1 : ACCESS;
      end
      ACCESS: begin
        if (w_err)              w_next = ERR1;
        else if (w_ack) begin
          if (REG_RESP != 0)    w_next = RESP;
          else if (w_accept)    w_next = w_dec_err ? ERR1 : ACCESS;
          else                  w_next = IDLE;
        end
        else if (w_tmo)         w_next = ERR1;
      end
      RESP, ERR2: begin
        if (w_accept) w_next = w_dec_err ? ERR1 : ACCESS;
        else          w_next = IDLE;
      end
      ERR1:    w_next = ERR2;
      default: w_next = IDLE;
    endcase
  end

  // Output logic: AHB response and channel request.
  always_comb begin
    ahb4_hready_o = 1'b1;
    ahb4_hresp_o  = HRESP_OKAY;
    ahb4_hrdata_o = '0;
    w_bus_en      = 1'b0;
    case (r_state)
      ACCESS: begin
        w_bus_en      = 1'b1;
        ahb4_hready_o = 1'b0;
        if ((REG_RESP == 0) && w_ack && !w_err) begin
          ahb4_hready_o = 1'b1;
          if (!r_write) ahb4_hrdata_o = w_rdata;
        end
      end
      RESP: begin
        if (!r_write) ahb4_hrdata_o = r_rdata;
      end
      ERR1: begin
        ahb4_hresp_o  = HRESP_ERROR;
        ahb4_hready_o = 1'b0;
      end
      ERR2: begin
        ahb4_hresp_o  = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  // Latch transfer direction and channel when an address phase is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_ch    <= '0;
    end else if (w_accept) begin
      r_write <= ahb4_hwrite_i;
      r_ch    <= w_ch;
    end
  end

  // Latch channel-local address bits when an address phase is taken.
  always_ff @(posedge clk) begin
    if (w_accept) r_addr <= ahb4_haddr_i[CH_LSB-1:0];
  end

  // Wait-cycle counter and registered timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_tmo <= w_tmo;
      if ((r_state == ACCESS) && !w_ack && !w_err) r_cnt <= r_cnt + 1'b1;
      else                                         r_cnt <= '0;
    end
  end

  // Capture read data on ack for the registered-response path.
  always_ff @(posedge clk) begin
    if ((r_state == ACCESS) && w_ack && !w_err && !r_write) r_rdata <= w_rdata;
  end

  // Channel fan-out and return mux.
  peripheral_mpi_bus_demux #(
    .PLEN     (PLEN),
    .XLEN     (XLEN),
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_demux (
    .i_en         (w_bus_en),
    .i_ch         (r_ch),
    .i_we         (r_write),
    .i_addr       (w_bus_addr),
    .i_wdata      (ahb4_hwdata_i),
    .o_ack        (w_ack),
    .o_err        (w_err),
    .o_rdata      (w_rdata),
    .bus_addr     (bus_addr),
    .bus_we       (bus_we),
    .bus_en       (bus_en),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .bus_ack      (bus_ack),
    .bus_err      (bus_err)
  );

endmodule
